pipeline_ctrl: RTL and testbench

Hazard and stall sequencer for the 5-stage pipeline. Detects load-use hazards the forwarding network cannot cover, flushes on taken branches, and freezes or bubbles pipeline stages during I-cache and D-cache misses through a single-outstanding memory handshake. Drains the pipeline on HLT. Sits beside the forwarding unit and drives the write-enables and flushes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/pipeline_ctrl_if.sv | 45 ++++
 rtl/load_use_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard-controller state encoding, stage control
// bundle and the NOP word that flush/bubble consumers load into a stage.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        D_MISS = 2'd1,
        I_MISS = 2'd2,
        HALT   = 2'd3
    } ctrl_state_e;

    // Encoding loaded into IF/ID, ID/EX or MEM/WB when flushed or bubbled.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Width of the HALT drain counter; HALT_DRAIN must fit in it.
    localparam int DRAIN_CNT_W = 3;

    // Per-stage hold / squash controls produced by the sequencer.
    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic stall_idex;
        logic stall_exmem;
        logic flush_ifid;
        logic bubble_idex;
        logic bubble_memwb;
    } stage_ctl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-sequencer bundle: pipeline hazard inputs, cache miss handshake and
// stage controls. master = sequencer side, slave = pipeline/memory side.
interface pipeline_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   MemRead_IDEX;
    logic [3:0]             DstReg_IDEX;
    logic [3:0]             SrcReg1_IFID;
    logic [3:0]             SrcReg2_IFID;
    logic                   src1_used_IFID;
    logic                   src2_used_IFID;
    logic                   MemWrite_IFID;
    logic                   branch_taken_ID;
    logic                   halt_ID;
    logic                   icache_miss;
    logic                   dcache_miss;
    logic                   mem_done;
    logic                   mem_req;
    logic                   mem_sel;
    logic                   stall_PC;
    logic                   stall_IFID;
    logic                   stall_IDEX;
    logic                   stall_EXMEM;
    logic                   flush_IFID;
    logic                   bubble_IDEX;
    logic                   bubble_MEMWB;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        input  MemRead_IDEX, DstReg_IDEX, SrcReg1_IFID, SrcReg2_IFID,
               src1_used_IFID, src2_used_IFID, MemWrite_IFID,
               branch_taken_ID, halt_ID, icache_miss, dcache_miss, mem_done,
        output mem_req, mem_sel, stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
               flush_IFID, bubble_IDEX, bubble_MEMWB, halted, stall_cycles
    );

    modport slave (
        output MemRead_IDEX, DstReg_IDEX, SrcReg1_IFID, SrcReg2_IFID,
               src1_used_IFID, src2_used_IFID, MemWrite_IFID,
               branch_taken_ID, halt_ID, icache_miss, dcache_miss, mem_done,
        input  mem_req, mem_sel, stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
               flush_IFID, bubble_IDEX, bubble_MEMWB, halted, stall_cycles
    );
endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX feeding a source the ID instruction
// really reads. Store data (src2 of a store) is excluded because MEM-to-MEM
// forwarding supplies it; R0 is hardwired and never a hazard.
module load_use_detect (
    input  logic       mem_read,
    input  logic [3:0] dst_reg,
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       src1_used,
    input  logic       src2_used,
    input  logic       store,
    output logic       load_use
);
    assign load_use = mem_read & (dst_reg != 4'd0) &
                      ((src1_used & (src1 == dst_reg)) |
                       (src2_used & ~store & (src2 == dst_reg)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use bubbles,
// taken-branch flush, single-outstanding I/D cache fill handshake and HLT drain.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int HALT_DRAIN  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.master bus
);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(HALT_DRAIN - 1);

    ctrl_state_e            state, state_nxt;
    stage_ctl_t             ctl;
    logic                   load_use;
    logic                   mem_req_q, mem_sel_q, halted_q;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;

    load_use_detect u_lud (
        .mem_read  (bus.MemRead_IDEX),
        .dst_reg   (bus.DstReg_IDEX),
        .src1      (bus.SrcReg1_IFID),
        .src2      (bus.SrcReg2_IFID),
        .src1_used (bus.src1_used_IFID),
        .src2_used (bus.src2_used_IFID),
        .store     (bus.MemWrite_IFID),
        .load_use  (load_use)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next state: D-miss beats I-miss beats HLT; a fill only ends on mem_done.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (bus.dcache_miss)                     state_nxt = D_MISS;
                else if (bus.icache_miss)                state_nxt = I_MISS;
                else if (bus.halt_ID && !load_use)       state_nxt = HALT;
            end
            D_MISS: if (bus.mem_done) state_nxt = bus.icache_miss ? I_MISS : RUN;
            I_MISS: if (bus.mem_done) state_nxt = bus.dcache_miss ? D_MISS : RUN;
            default: state_nxt = HALT;
        endcase
    end

    // Stage controls; all quiet while reset is held.
    always_comb begin
        ctl = '0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (bus.dcache_miss) begin
                        ctl.stall_pc     = 1'b1;
                        ctl.stall_ifid   = 1'b1;
                        ctl.stall_idex   = 1'b1;
                        ctl.stall_exmem  = 1'b1;
                        ctl.bubble_memwb = 1'b1;
                    end else begin
                        // An I-miss coinciding with load-use must hold IF/ID
                        // rather than flush it, or the dependent op is lost.
                        ctl.stall_pc    = load_use | bus.icache_miss;
                        ctl.stall_ifid  = load_use;
                        ctl.bubble_idex = load_use;
                        ctl.flush_ifid  = ~load_use & (bus.branch_taken_ID | bus.icache_miss);
                    end
                end
                D_MISS: begin
                    ctl.stall_pc     = 1'b1;
                    ctl.stall_ifid   = 1'b1;
                    ctl.stall_idex   = 1'b1;
                    ctl.stall_exmem  = 1'b1;
                    ctl.bubble_memwb = 1'b1;
                end
                default: begin
                    // I_MISS and HALT: no new fetch, downstream keeps moving.
                    ctl.stall_pc   = 1'b1;
                    ctl.flush_ifid = 1'b1;
                end
            endcase
        end
    end

    // Fill request tracks the miss state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q <= 1'b0;
            mem_sel_q <= 1'b0;
        end else begin
            mem_req_q <= (state_nxt == D_MISS) || (state_nxt == I_MISS);
            mem_sel_q <= (state_nxt == D_MISS);
        end
    end

    // HALT drain counter; halted latches once the drain window has elapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
            halted_q  <= 1'b0;
        end else if (state == HALT && !halted_q) begin
            drain_cnt <= drain_cnt + DRAIN_CNT_W'(1);
            if (drain_cnt == DRAIN_LAST) halted_q <= 1'b1;
        end
    end

    // Saturating count of stalled cycles, excluding the HLT drain.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (ctl.stall_pc && state != HALT && stall_cnt != '1)
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_sel      = mem_sel_q;
    assign bus.halted       = halted_q;
    assign bus.stall_cycles = stall_cnt;
    assign bus.stall_PC     = ctl.stall_pc;
    assign bus.stall_IFID   = ctl.stall_ifid;
    assign bus.stall_IDEX   = ctl.stall_idex;
    assign bus.stall_EXMEM  = ctl.stall_exmem;
    assign bus.flush_IFID   = ctl.flush_ifid;
    assign bus.bubble_IDEX  = ctl.bubble_idex;
    assign bus.bubble_MEMWB = ctl.bubble_memwb;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: decode vector table, hand-written multi-cycle
// sequences and a randomized run against a behavioural reference model.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.STALL_CNT_W(16)) bus ();

    pipeline_ctrl #(.HALT_DRAIN(4), .STALL_CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, bubble_IDEX, bubble_MEMWB}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100010;
    localparam logic [6:0] O_BR   = 7'b0000100;
    localparam logic [6:0] O_DM   = 7'b1111001;
    localparam logic [6:0] O_IM   = 7'b1000100;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       mr;
        logic [3:0] dst, s1, s2;
        logic       u1, u2, st, br;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl[12];

    // reference model state
    bit m_dfill, m_ifill, m_halt;
    int m_age, m_stalls;

    function automatic logic [6:0] outs();
        return {bus.stall_PC, bus.stall_IFID, bus.stall_IDEX, bus.stall_EXMEM,
                bus.flush_IFID, bus.bubble_IDEX, bus.bubble_MEMWB};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.MemRead_IDEX = 0; bus.DstReg_IDEX = 0; bus.SrcReg1_IFID = 0; bus.SrcReg2_IFID = 0;
        bus.src1_used_IFID = 0; bus.src2_used_IFID = 0; bus.MemWrite_IFID = 0;
        bus.branch_taken_ID = 0; bus.halt_ID = 0; bus.icache_miss = 0;
        bus.dcache_miss = 0; bus.mem_done = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
    endtask

    // Hazard rule evaluated straight from the decode fields.
    function automatic bit hazard();
        bit hit1, hit2;
        hit1 = bus.src1_used_IFID && (bus.SrcReg1_IFID == bus.DstReg_IDEX);
        hit2 = bus.src2_used_IFID && !bus.MemWrite_IFID && (bus.SrcReg2_IFID == bus.DstReg_IDEX);
        return bus.MemRead_IDEX && (bus.DstReg_IDEX != 0) && (hit1 || hit2);
    endfunction

    function automatic logic [6:0] model_out();
        bit hz;
        hz = hazard();
        if (rst) return O_NONE;
        if (m_halt || m_ifill) return O_IM;
        if (m_dfill || bus.dcache_miss) return O_DM;
        if (hz) return O_LU;
        if (bus.icache_miss || bus.branch_taken_ID) return O_IM & {1'b0, 6'h3F} | (bus.icache_miss ? O_IM : O_BR);
        return O_NONE;
    endfunction

    task automatic model_step();
        logic [6:0] o;
        bit hz;
        o  = model_out();
        hz = hazard();
        if (rst) begin
            m_dfill = 0; m_ifill = 0; m_halt = 0; m_age = 0; m_stalls = 0;
            return;
        end
        if (o[6] && !m_halt && m_stalls < 65535) m_stalls++;
        if (m_halt) begin
            if (m_age < 100) m_age++;
        end else if (m_dfill) begin
            if (bus.mem_done) begin m_dfill = 0; m_ifill = bus.icache_miss; end
        end else if (m_ifill) begin
            if (bus.mem_done) begin m_ifill = 0; m_dfill = bus.dcache_miss; end
        end else if (bus.dcache_miss) m_dfill = 1;
        else if (bus.icache_miss) m_ifill = 1;
        else if (bus.halt_ID && !hz) begin m_halt = 1; m_age = 0; end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd3, 4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_LU};   // ADD reads R3 via src1
        tbl[1]  = '{1'b1, 4'd3, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, O_LU};   // src2 match
        tbl[2]  = '{1'b1, 4'd3, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, O_NONE}; // SW data R3
        tbl[3]  = '{1'b1, 4'd3, 4'd3, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, O_LU};   // SW base R3
        tbl[4]  = '{1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, O_NONE}; // R0 dest
        tbl[5]  = '{1'b0, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, O_NONE}; // not a load
        tbl[6]  = '{1'b1, 4'd3, 4'd3, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE}; // src1 unused
        tbl[7]  = '{1'b0, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, O_BR};   // branch
        tbl[8]  = '{1'b1, 4'd9, 4'd9, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, O_LU};   // load-use beats branch
        tbl[9]  = '{1'b1, 4'd9, 4'd8, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, O_NONE};// no match
        tbl[10] = '{1'b1, 4'd9, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, O_BR};   // load, branch, no match
        tbl[11] = '{1'b1, 4'd6, 4'd1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE}; // src2 unused

        // ---- reset state, with busy inputs held during reset
        clr_in();
        rst = 1'b1;
        bus.dcache_miss = 1; bus.branch_taken_ID = 1;
        bus.MemRead_IDEX = 1; bus.DstReg_IDEX = 4'd3; bus.SrcReg1_IFID = 4'd3; bus.src1_used_IFID = 1;
        next(); next();
        @(negedge clk);
        chk("rst_outs", outs(), O_NONE);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_sel", bus.mem_sel, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_stall_cycles", bus.stall_cycles, 0);
        do_reset();

        // ---- decode table in RUN
        for (int i = 0; i < 12; i++) begin
            bus.MemRead_IDEX = tbl[i].mr; bus.DstReg_IDEX = tbl[i].dst;
            bus.SrcReg1_IFID = tbl[i].s1; bus.SrcReg2_IFID = tbl[i].s2;
            bus.src1_used_IFID = tbl[i].u1; bus.src2_used_IFID = tbl[i].u2;
            bus.MemWrite_IFID = tbl[i].st; bus.branch_taken_ID = tbl[i].br;
            @(negedge clk);
            chk($sformatf("vec%0d_outs", i), outs(), tbl[i].exp);
            chk($sformatf("vec%0d_mem_req", i), bus.mem_req, 0);
            next();
        end

        // ---- load-use + branch: one bubble, branch flushes next cycle
        do_reset();
        bus.MemRead_IDEX = 1; bus.DstReg_IDEX = 4'd3; bus.SrcReg1_IFID = 4'd3;
        bus.src1_used_IFID = 1; bus.branch_taken_ID = 1;
        @(negedge clk); chk("lu_br_c0", outs(), O_LU);
        next();
        bus.MemRead_IDEX = 0;
        @(negedge clk); chk("lu_br_c1", outs(), O_BR);
        next();
        bus.branch_taken_ID = 0;
        @(negedge clk); chk("lu_br_c2", outs(), O_NONE);
        chk("lu_br_stalls", bus.stall_cycles, 1);

        // ---- D-cache miss, mem_done 10 cycles after mem_req rises
        do_reset();
        bus.dcache_miss = 1;
        @(negedge clk);
        chk("dm_c0_outs", outs(), O_DM);
        chk("dm_c0_req", bus.mem_req, 0);
        next();
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) begin bus.mem_done = 1; bus.dcache_miss = 0; end
            @(negedge clk);
            chk($sformatf("dm_c%0d_outs", k), outs(), O_DM);
            chk($sformatf("dm_c%0d_req", k), {bus.mem_req, bus.mem_sel}, 2'b11);
            next();
        end
        bus.mem_done = 0;
        @(negedge clk);
        chk("dm_done_req", bus.mem_req, 0);
        chk("dm_done_outs", outs(), O_NONE);
        chk("dm_stall_cycles", bus.stall_cycles, 11);

        // ---- I-cache miss with a D-miss arriving mid-fill
        do_reset();
        bus.icache_miss = 1;
        @(negedge clk); chk("im_c0_outs", outs(), O_IM);
        next();
        bus.icache_miss = 0;
        @(negedge clk);
        chk("im_c1_req", {bus.mem_req, bus.mem_sel}, 2'b10);
        chk("im_c1_outs", outs(), O_IM);
        next();
        bus.dcache_miss = 1;
        @(negedge clk);
        chk("im_c2_sel", {bus.mem_req, bus.mem_sel}, 2'b10);
        chk("im_c2_outs", outs(), O_IM);
        next();
        bus.mem_done = 1;
        @(negedge clk);
        chk("im_c3_sel", {bus.mem_req, bus.mem_sel}, 2'b10);
        chk("im_c3_outs", outs(), O_IM);
        next();
        bus.mem_done = 0;
        @(negedge clk);
        chk("im_to_dm_sel", {bus.mem_req, bus.mem_sel}, 2'b11);
        chk("im_to_dm_outs", outs(), O_DM);
        next();
        bus.mem_done = 1; bus.dcache_miss = 0;
        next();
        bus.mem_done = 0;
        @(negedge clk);
        chk("im_end_req", bus.mem_req, 0);

        // ---- HLT drain, sticky halted, D-miss ignored, reset recovers
        do_reset();
        bus.halt_ID = 1;
        @(negedge clk); chk("halt_c0_outs", outs(), O_NONE);
        next();
        bus.halt_ID = 0; bus.dcache_miss = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("halt_c%0d_outs", k), outs(), O_IM);
            chk($sformatf("halt_c%0d_halted", k), bus.halted, (k >= 5) ? 1 : 0);
            chk($sformatf("halt_c%0d_req", k), bus.mem_req, 0);
            next();
        end
        @(negedge clk); chk("halt_stall_cycles", bus.stall_cycles, 0);
        next();
        rst = 1;
        @(negedge clk); chk("halt_rst_outs", outs(), O_NONE);
        next();
        rst = 0; bus.dcache_miss = 0; bus.branch_taken_ID = 1;
        @(negedge clk);
        chk("halt_rst_halted", bus.halted, 0);
        chk("halt_rst_run", outs(), O_BR);
        next();
        bus.branch_taken_ID = 0;

        // ---- reset in the middle of a D-side fill
        do_reset();
        bus.dcache_miss = 1;
        next();
        @(negedge clk); chk("rstdm_req_before", bus.mem_req, 1);
        next();
        rst = 1;
        @(negedge clk); chk("rstdm_outs_in_rst", outs(), O_NONE);
        next();
        rst = 0; bus.dcache_miss = 0;
        @(negedge clk);
        chk("rstdm_req_after", bus.mem_req, 0);
        chk("rstdm_outs_after", outs(), O_NONE);
        chk("rstdm_stall_cycles", bus.stall_cycles, 0);

        // ---- stall counter saturation
        do_reset();
        bus.dcache_miss = 1;
        repeat (65534) next();
        @(negedge clk); chk("sat_fffe", bus.stall_cycles, 16'hFFFE);
        repeat (6) next();
        @(negedge clk); chk("sat_ffff", bus.stall_cycles, 16'hFFFF);
        chk("sat_still_req", bus.mem_req, 1);

        // ---- randomized run against the reference model
        do_reset();
        m_dfill = 0; m_ifill = 0; m_halt = 0; m_age = 0; m_stalls = 0;
        for (int n = 0; n < 1500; n++) begin
            rst                 = ($urandom_range(0, 49) == 0);
            bus.MemRead_IDEX    = 1'($urandom);
            bus.DstReg_IDEX     = 4'($urandom_range(0, 3));
            bus.SrcReg1_IFID    = 4'($urandom_range(0, 3));
            bus.SrcReg2_IFID    = 4'($urandom_range(0, 3));
            bus.src1_used_IFID  = 1'($urandom);
            bus.src2_used_IFID  = 1'($urandom);
            bus.MemWrite_IFID   = 1'($urandom);
            bus.branch_taken_ID = 1'($urandom);
            bus.halt_ID         = ($urandom_range(0, 24) == 0);
            bus.icache_miss     = ($urandom_range(0, 9) == 0);
            bus.dcache_miss     = ($urandom_range(0, 11) == 0);
            bus.mem_done        = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            chk("rnd_outs", outs(), model_out());
            chk("rnd_mem", {bus.mem_req, bus.mem_sel}, {m_dfill || m_ifill, m_dfill});
            chk("rnd_halted", bus.halted, (m_halt && m_age >= 4) ? 1 : 0);
            chk("rnd_stall_cycles", bus.stall_cycles, m_stalls);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
